// File: rtl/snoop_bus_controller_if.sv
// Cache-side and RAM-side signal bundle for the snoopy bus controller.
interface snoop_bus_controller_if #(
  parameter int unsigned NCPU = 2
);
  logic [NCPU-1:0]       dREN;
  logic [NCPU-1:0]       dWEN;
  logic [NCPU-1:0]       cctrans;
  logic [NCPU-1:0]       ccwrite;
  logic [NCPU-1:0][31:0] daddr;
  logic [NCPU-1:0][31:0] dstore;
  logic [NCPU-1:0]       dwait;
  logic [NCPU-1:0][31:0] dload;
  logic [NCPU-1:0]       ccwait;
  logic [NCPU-1:0]       ccinv;
  logic [NCPU-1:0][31:0] ccsnoopaddr;
  logic [1:0]            ramstate;
  logic [31:0]           ramload;
  logic                  ramREN;
  logic                  ramWEN;
  logic [31:0]           ramaddr;
  logic [31:0]           ramstore;

  modport master (
    input  dREN, dWEN, cctrans, ccwrite, daddr, dstore, ramstate, ramload,
    output dwait, dload, ccwait, ccinv, ccsnoopaddr, ramREN, ramWEN, ramaddr, ramstore
  );

  modport slave (
    output dREN, dWEN, cctrans, ccwrite, daddr, dstore, ramstate, ramload,
    input  dwait, dload, ccwait, ccinv, ccsnoopaddr, ramREN, ramWEN, ramaddr, ramstore
  );
endinterface

// File: rtl/snoop_bus_controller.sv
// MSI snoopy bus controller: round-robin serialisation of cache coherence
// transactions onto one shared RAM port, with peer-to-peer block forwarding.
module snoop_bus_controller #(
  parameter int unsigned NCPU      = 2,
  parameter int unsigned WORDS     = 2,
  parameter int unsigned SNOOP_CYC = 2
) (
  input logic                    CLK,
  input logic                    nRST,
  snoop_bus_controller_if.master bus
);
  localparam int unsigned IW = (NCPU > 1) ? $clog2(NCPU) : 1;
  localparam int unsigned CW = $clog2(WORDS) + 1;
  localparam int unsigned SW = $clog2(SNOOP_CYC) + 1;
  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [1:0] RAM_ERROR  = 2'd3;

  typedef enum logic [2:0] {IDLE, INV, SNOOP, FWD, LOAD, WB} state_t;

  state_t        state, state_n;
  logic [IW-1:0] req, req_n, sup, sup_n, lastg, lastg_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [SW-1:0] scnt, scnt_n;
  logic          cw, cw_n, gap, gap_n;

  logic [NCPU-1:0] rset, others;
  logic            gnt_found, sup_found, acc, abort;
  logic [IW-1:0]   gnt_idx, sup_idx;

  // Round-robin grant after the last winner; supplier search after the requester.
  always_comb begin
    rset      = bus.cctrans | bus.dWEN;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    sup_found = 1'b0;
    sup_idx   = '0;
    for (int k = 1; k <= int'(NCPU); k++) begin
      if (!gnt_found && rset[IW'((int'(lastg) + k) % int'(NCPU))]) begin
        gnt_found = 1'b1;
        gnt_idx   = IW'((int'(lastg) + k) % int'(NCPU));
      end
    end
    for (int k = 1; k < int'(NCPU); k++) begin
      if (!sup_found && bus.cctrans[IW'((int'(req) + k) % int'(NCPU))]) begin
        sup_found = 1'b1;
        sup_idx   = IW'((int'(req) + k) % int'(NCPU));
      end
    end
    others      = '1;
    others[req] = 1'b0;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
      req   <= '0;
      sup   <= '0;
      lastg <= '0;
      cnt   <= '0;
      scnt  <= '0;
      cw    <= 1'b0;
      gap   <= 1'b0;
    end else begin
      state <= state_n;
      req   <= req_n;
      sup   <= sup_n;
      lastg <= lastg_n;
      cnt   <= cnt_n;
      scnt  <= scnt_n;
      cw    <= cw_n;
      gap   <= gap_n;
    end
  end

  always_comb begin
    state_n      = state;
    req_n        = req;
    sup_n        = sup;
    lastg_n      = lastg;
    cnt_n        = cnt;
    scnt_n       = scnt;
    cw_n         = cw;
    gap_n        = 1'b0;
    acc          = 1'b0;
    abort        = 1'b0;
    bus.dwait    = '1;
    bus.dload    = '0;
    bus.ccwait   = '0;
    bus.ccinv    = '0;
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = '0;
    bus.ramstore = '0;
    for (int i = 0; i < int'(NCPU); i++)
      bus.ccsnoopaddr[IW'(i)] = (state == IDLE) ? 32'h0 : bus.daddr[req];

    unique case (state)
      IDLE: begin
        if (gnt_found) begin
          req_n  = gnt_idx;
          cw_n   = bus.ccwrite[gnt_idx];
          scnt_n = '0;
          cnt_n  = '0;
          if (bus.dWEN[gnt_idx])      state_n = WB;
          else if (bus.dREN[gnt_idx]) state_n = SNOOP;
          else                        state_n = INV;
        end
      end
      INV: begin
        bus.ccinv = others;
        state_n   = IDLE;
      end
      SNOOP: begin
        bus.ccwait = others;
        bus.ccinv  = cw ? others : '0;
        if (scnt == SW'(SNOOP_CYC - 1)) begin
          sup_n   = sup_idx;
          cnt_n   = '0;
          state_n = sup_found ? FWD : LOAD;
        end else begin
          scnt_n = scnt + 1'b1;
        end
      end
      FWD: begin
        bus.ccwait = others;
        if (!gap) begin
          bus.dload[req] = bus.dstore[sup];
          if (cw) begin
            // Ownership moves to the requester; RAM copy stays stale.
            bus.dwait[req] = 1'b0;
            bus.dwait[sup] = 1'b0;
            acc            = 1'b1;
          end else begin
            bus.ramWEN   = 1'b1;
            bus.ramaddr  = bus.daddr[sup];
            bus.ramstore = bus.dstore[sup];
            if (bus.ramstate == RAM_ACCESS) begin
              bus.dwait[req] = 1'b0;
              bus.dwait[sup] = 1'b0;
              acc            = 1'b1;
            end else if (bus.ramstate == RAM_ERROR) begin
              abort = 1'b1;
            end
          end
        end
      end
      LOAD: begin
        bus.ccwait = others;
        if (!gap) begin
          bus.ramREN     = 1'b1;
          bus.ramaddr    = bus.daddr[req];
          bus.dload[req] = bus.ramload;
          if (bus.ramstate == RAM_ACCESS) begin
            bus.dwait[req] = 1'b0;
            acc            = 1'b1;
          end else if (bus.ramstate == RAM_ERROR) begin
            abort = 1'b1;
          end
        end
      end
      WB: begin
        if (!gap) begin
          bus.ramWEN   = 1'b1;
          bus.ramaddr  = bus.daddr[req];
          bus.ramstore = bus.dstore[req];
          if (bus.ramstate == RAM_ACCESS) begin
            bus.dwait[req] = 1'b0;
            acc            = 1'b1;
          end else if (bus.ramstate == RAM_ERROR) begin
            abort = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    // Word bookkeeping: a gap cycle follows every non-final word.
    if (acc) begin
      if (cnt == CW'(WORDS - 1)) begin
        state_n = IDLE;
      end else begin
        cnt_n = cnt + 1'b1;
        gap_n = 1'b1;
      end
    end
    if (abort) state_n = IDLE;
    if (state != IDLE && state_n == IDLE) lastg_n = req;
  end
endmodule

// File: tb/tb_snoop_bus_controller.sv
// Directed bench for snoop_bus_controller with NCPU=4, WORDS=2, SNOOP_CYC=2.
module tb_snoop_bus_controller;
  localparam logic [1:0] RS_FREE   = 2'd0;
  localparam logic [1:0] RS_BUSY   = 2'd1;
  localparam logic [1:0] RS_ACCESS = 2'd2;
  localparam logic [1:0] RS_ERROR  = 2'd3;

  logic CLK = 1'b0;
  logic nRST;
  int   errors = 0;
  int   checks = 0;

  snoop_bus_controller_if #(.NCPU(4)) bus ();

  snoop_bus_controller #(.NCPU(4), .WORDS(2), .SNOOP_CYC(2)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // {2'b0, ramREN, ramWEN}
  function automatic logic [3:0] en();
    return {2'b00, bus.ramREN, bus.ramWEN};
  endfunction

  task automatic cyc();
    @(negedge CLK);
  endtask

  task automatic clear();
    bus.dREN     = '0;
    bus.dWEN     = '0;
    bus.cctrans  = '0;
    bus.ccwrite  = '0;
    bus.daddr    = '0;
    bus.dstore   = '0;
    bus.ramstate = RS_FREE;
    bus.ramload  = '0;
  endtask

  initial begin
    clear();
    nRST = 1'b1;
    #2 nRST = 1'b0;
    #1;
    chk4("rst_dwait", bus.dwait, 4'hF);
    chk4("rst_ccwait", bus.ccwait, 4'h0);
    chk4("rst_ccinv", bus.ccinv, 4'h0);
    chk4("rst_en", en(), 4'h0);
    chk32("rst_snpaddr", bus.ccsnoopaddr[0], 32'h0);
    chk32("rst_dload", bus.dload[2], 32'h0);
    cyc(); cyc(); nRST = 1'b1;

    // Cache 2 read miss, no snoop hits, RAM two-cycle latency
    cyc(); bus.dREN[2] = 1'b1; bus.cctrans[2] = 1'b1; bus.daddr[2] = 32'h100; #1;
    chk4("t1_idle_dwait", bus.dwait, 4'hF);
    cyc(); #1;
    chk4("t1_snp_ccwait", bus.ccwait, 4'b1011);
    chk4("t1_snp_ccinv", bus.ccinv, 4'b0000);
    chk32("t1_snpaddr3", bus.ccsnoopaddr[3], 32'h100);
    cyc(); #1;
    chk4("t1_snp2_ccwait", bus.ccwait, 4'b1011);
    cyc(); bus.ramstate = RS_BUSY; #1;
    chk4("t1_w0_busy_en", en(), 4'b0010);
    chk32("t1_w0_addr", bus.ramaddr, 32'h100);
    chk4("t1_w0_busy_dwait", bus.dwait, 4'hF);
    chk4("t1_w0_ccwait", bus.ccwait, 4'b1011);
    cyc(); bus.ramstate = RS_ACCESS; bus.ramload = 32'h1111_1111; #1;
    chk4("t1_w0_acc_dwait", bus.dwait, 4'b1011);
    chk32("t1_w0_dload", bus.dload[2], 32'h1111_1111);
    cyc(); bus.ramstate = RS_FREE; bus.daddr[2] = 32'h104; #1;
    chk4("t1_gap_en", en(), 4'b0000);
    chk4("t1_gap_dwait", bus.dwait, 4'hF);
    chk4("t1_gap_ccwait", bus.ccwait, 4'b1011);
    cyc(); bus.ramstate = RS_BUSY; #1;
    chk32("t1_w1_addr", bus.ramaddr, 32'h104);
    chk4("t1_w1_busy_dwait", bus.dwait, 4'hF);
    cyc(); bus.ramstate = RS_ACCESS; bus.ramload = 32'h2222_2222; #1;
    chk4("t1_w1_acc_dwait", bus.dwait, 4'b1011);
    chk32("t1_w1_dload", bus.dload[2], 32'h2222_2222);
    cyc(); clear(); #1;
    chk4("t1_done_dwait", bus.dwait, 4'hF);
    chk4("t1_done_ccwait", bus.ccwait, 4'h0);
    chk4("t1_done_en", en(), 4'h0);

    // Cache 0 read miss, cache 3 supplies (M->S with RAM writeback)
    cyc(); bus.dREN[0] = 1'b1; bus.cctrans[0] = 1'b1; bus.daddr[0] = 32'h200; #1;
    cyc(); bus.cctrans[3] = 1'b1; bus.dstore[3] = 32'hDEAD_BEEF; bus.daddr[3] = 32'h200; #1;
    chk4("t2_snp_ccwait", bus.ccwait, 4'b1110);
    chk4("t2_snp_ccinv", bus.ccinv, 4'h0);
    cyc(); #1;
    chk4("t2_snp2_ccinv", bus.ccinv, 4'h0);
    cyc(); bus.ramstate = RS_BUSY; #1;
    chk4("t2_w0_en", en(), 4'b0001);
    chk32("t2_w0_addr", bus.ramaddr, 32'h200);
    chk32("t2_w0_store", bus.ramstore, 32'hDEAD_BEEF);
    chk32("t2_w0_dload", bus.dload[0], 32'hDEAD_BEEF);
    chk4("t2_w0_busy_dwait", bus.dwait, 4'hF);
    cyc(); bus.ramstate = RS_ACCESS; #1;
    chk4("t2_w0_acc_dwait", bus.dwait, 4'b0110);
    chk4("t2_w0_ccinv", bus.ccinv, 4'h0);
    cyc(); bus.ramstate = RS_FREE; bus.dstore[3] = 32'hCAFE_F00D;
    bus.daddr[3] = 32'h204; bus.daddr[0] = 32'h204; #1;
    chk4("t2_gap_en", en(), 4'h0);
    chk4("t2_gap_dwait", bus.dwait, 4'hF);
    cyc(); bus.ramstate = RS_ACCESS; #1;
    chk32("t2_w1_dload", bus.dload[0], 32'hCAFE_F00D);
    chk32("t2_w1_addr", bus.ramaddr, 32'h204);
    chk32("t2_w1_store", bus.ramstore, 32'hCAFE_F00D);
    chk4("t2_w1_dwait", bus.dwait, 4'b0110);
    cyc(); clear(); #1;
    chk4("t2_done_en", en(), 4'h0);
    chk4("t2_done_ccwait", bus.ccwait, 4'h0);

    // Cache 1 read-exclusive, cache 0 supplies (M->I, no RAM)
    cyc(); bus.dREN[1] = 1'b1; bus.cctrans[1] = 1'b1; bus.ccwrite[1] = 1'b1; bus.daddr[1] = 32'h300; #1;
    cyc(); bus.cctrans[0] = 1'b1; bus.dstore[0] = 32'hAAAA_0001; #1;
    chk4("t3_snp_ccwait", bus.ccwait, 4'b1101);
    chk4("t3_snp_ccinv", bus.ccinv, 4'b1101);
    cyc(); #1;
    chk4("t3_snp2_ccinv", bus.ccinv, 4'b1101);
    cyc(); #1;
    chk4("t3_w0_en", en(), 4'h0);
    chk4("t3_w0_dwait", bus.dwait, 4'b1100);
    chk32("t3_w0_dload", bus.dload[1], 32'hAAAA_0001);
    cyc(); bus.dstore[0] = 32'hAAAA_0002; #1;
    chk4("t3_gap_dwait", bus.dwait, 4'hF);
    chk4("t3_gap_en", en(), 4'h0);
    cyc(); #1;
    chk4("t3_w1_dwait", bus.dwait, 4'b1100);
    chk32("t3_w1_dload", bus.dload[1], 32'hAAAA_0002);
    chk4("t3_w1_en", en(), 4'h0);
    cyc(); clear(); #1;
    chk4("t3_done_ccwait", bus.ccwait, 4'h0);
    chk4("t3_done_dwait", bus.dwait, 4'hF);

    // Upgrades from cache 2 then cache 3: one INV cycle each
    cyc(); bus.cctrans[2] = 1'b1; #1;
    chk4("t4_idle_ccinv", bus.ccinv, 4'h0);
    cyc(); bus.cctrans[2] = 1'b0; #1;
    chk4("t4_inv2_ccinv", bus.ccinv, 4'b1011);
    chk4("t4_inv2_dwait", bus.dwait, 4'hF);
    cyc(); bus.cctrans[3] = 1'b1; #1;
    chk4("t4_idle2_ccinv", bus.ccinv, 4'h0);
    cyc(); bus.cctrans[3] = 1'b0; #1;
    chk4("t4_inv3_ccinv", bus.ccinv, 4'b0111);

    // Caches 0,1,3 request together and keep requesting: grants 0,1,3,0
    cyc(); bus.cctrans = 4'b1011; #1;
    chk4("t5_idle0", bus.ccinv, 4'h0);
    cyc(); #1;
    chk4("t5_g0_ccinv", bus.ccinv, 4'b1110);
    chk4("t5_g0_dwait", bus.dwait, 4'hF);
    cyc(); #1;
    chk4("t5_idle1", bus.ccinv, 4'h0);
    cyc(); #1;
    chk4("t5_g1_ccinv", bus.ccinv, 4'b1101);
    cyc(); #1;
    chk4("t5_idle2", bus.ccinv, 4'h0);
    cyc(); #1;
    chk4("t5_g3_ccinv", bus.ccinv, 4'b0111);
    cyc(); #1;
    chk4("t5_idle3", bus.ccinv, 4'h0);
    cyc(); bus.cctrans = 4'b0000; #1;
    chk4("t5_g0b_ccinv", bus.ccinv, 4'b1110);

    // Cache 1 writeback, RAM error on the second word
    cyc(); bus.dWEN[1] = 1'b1; bus.daddr[1] = 32'h400; bus.dstore[1] = 32'h1234_5678; #1;
    chk4("t6_idle_en", en(), 4'h0);
    cyc(); bus.ramstate = RS_ACCESS; #1;
    chk4("t6_w0_en", en(), 4'b0001);
    chk32("t6_w0_addr", bus.ramaddr, 32'h400);
    chk32("t6_w0_store", bus.ramstore, 32'h1234_5678);
    chk4("t6_w0_dwait", bus.dwait, 4'b1101);
    cyc(); bus.ramstate = RS_FREE; bus.daddr[1] = 32'h404; bus.dstore[1] = 32'h9ABC_DEF0; #1;
    chk4("t6_gap_en", en(), 4'h0);
    cyc(); bus.ramstate = RS_ERROR; #1;
    chk4("t6_err_en", en(), 4'b0001);
    chk4("t6_err_dwait", bus.dwait, 4'hF);
    cyc(); clear(); bus.cctrans = 4'b0110; #1;
    chk4("t6_idle_en2", en(), 4'h0);
    chk4("t6_idle_dwait", bus.dwait, 4'hF);
    cyc(); bus.cctrans = 4'b0000; #1;
    chk4("t6_next_grant", bus.ccinv, 4'b1011);

    // Asynchronous reset in the middle of a LOAD
    cyc(); bus.dREN[0] = 1'b1; bus.cctrans[0] = 1'b1; bus.daddr[0] = 32'h500; #1;
    cyc(); #1;
    chk4("t7_snp_ccwait", bus.ccwait, 4'b1110);
    cyc(); #1;
    cyc(); bus.ramstate = RS_BUSY; #1;
    chk4("t7_load_en", en(), 4'b0010);
    chk32("t7_load_addr", bus.ramaddr, 32'h500);
    #2 nRST = 1'b0;
    #1;
    chk4("t7_rst_en", en(), 4'h0);
    chk4("t7_rst_dwait", bus.dwait, 4'hF);
    chk4("t7_rst_ccwait", bus.ccwait, 4'h0);
    chk32("t7_rst_addr", bus.ramaddr, 32'h0);
    chk32("t7_rst_snpaddr", bus.ccsnoopaddr[1], 32'h0);
    cyc(); bus.ramstate = RS_ACCESS; #1;
    chk4("t7_hold_en", en(), 4'h0);
    cyc(); clear(); nRST = 1'b1; #1;
    chk4("t7_rel_en", en(), 4'h0);
    chk4("t7_rel_ccwait", bus.ccwait, 4'h0);
    cyc(); #1;
    chk4("t7_idle_en", en(), 4'h0);
    chk4("t7_idle_dwait", bus.dwait, 4'hF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
